pc_sequencer: RTL
=================

# pc_sequencer

Fetch controller that owns the program counter and sequences the next-address (MUX C) selection of the datapath. It issues one-outstanding instruction fetches over a request/grant/response handshake, and advances the PC by one per fetch. It redirects the PC when the execute stage reports a taken branch or jump, squashing any fetch already in flight. It sits between the decode/execute branch logic (BS, PS, Z, BrA, RAA) and instruction memory.

## Interface
- `AW`, default 32: PC/address width.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold: no new fetch request is started while high.
- `br_valid`  in  1  branch control below is valid this cycle.
- `bs`  in  2  branch select {BS1, BS0}.
- `ps`  in  1  polarity select.
- `z`  in  1  zero flag from execute.
- `bra`  in  AW  branch target address.
- `raa`  in  AW  register (jump) target address.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  AW  fetch address; equals PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction.
- `inst_valid`  out  1  registered; `inst`/`inst_pc`/`pc_1` are valid.
- `inst`  out  32  fetched instruction.
- `inst_pc`  out  AW  address of `inst`.
- `pc_1`  out  AW  `inst_pc + 1` (mod 2^AW), forwarded down the pipe.
- `flush`  out  1  one-cycle pulse after a taken redirect.

## Operation
- Select: `sel = {bs[1], bs[0] & (bs[1] | (ps ^ z))}`.
  - 0: sequential. 1: `bra`. 2: `raa`. 3: `bra`.
  - taken = `br_valid & (sel != 0)`.
- States:
  - RST: entered by reset; lasts one cycle after `rst_n` release.
  - HOLD
  - REQ
  - WAIT
- Transitions:
  - RST -> HOLD if `stall`, else REQ.
  - REQ: `imem_req=1`, `imem_addr=pc`.
    - On `imem_gnt`: PC <= PC+1, latch the fetch PC, go to WAIT.
    - Request stays asserted until granted; `stall` does not withdraw it.
  - WAIT: on `imem_rvalid`, go to HOLD if `stall`, else REQ.
    - If `squash` is clear: register `inst`, `inst_pc`, `pc_1`, and set `inst_valid` for one cycle.
    - If `squash` is set: drop the data and clear `squash`.
  - HOLD -> REQ when `!stall`.
- Taken branch: PC <= target on the same edge, in any non-RST state. It has priority over `stall` and over the `imem_gnt` increment.
  - Taken in WAIT: set `squash`.
  - Taken in REQ with `imem_gnt` in the same cycle: the grant completes, state goes to WAIT, `squash` is set, and PC <= target (not PC+1).
  - Taken in REQ without grant: `imem_addr` changes to the target next cycle. This is the only allowed change of a pending address.
- Arithmetic: all PC math is unsigned, modulo 2^AW. 0xFFFFFFFF+1 = 0.
- `br_valid` with sel=0 has no effect.
- `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values:
  - PC = `RESET_PC`; state = RST.
  - `imem_req` = 0, `inst_valid` = 0, `flush` = 0, `squash` = 0.
  - `inst` = 0, `inst_pc` = 0, `pc_1` = 0.
- `imem_req`/`imem_addr` are decoded from registered state and PC, with no combinational path from inputs.
- `imem_rvalid` may arrive no earlier than the cycle after `imem_gnt`.
- `inst_valid` rises one cycle after the accepted `imem_rvalid`.
- Zero-wait memory: requests are granted every 2nd cycle; first `inst_valid` is at cycle 3 after reset release.
- `flush` is high exactly one cycle, on the cycle after the taken branch is sampled.
- Reset asserted mid-fetch: everything clears immediately, and the pending response is never delivered. Memory is reset by the same `rst_n`.

## Test plan
- Reset release, `RESET_PC`=0, zero-wait memory returning `rdata` = 0xA0+addr -> fetches at 0, 1, 2; `inst_valid` shows {0xA0, pc 0, pc_1 1}, {0xA1, 1, 2}, {0xA2, 2, 3}.
- Branch encodings with `bra`=0x40, `raa`=0x80:
  - bs=01, ps=1, z=0 -> next fetch at 0x40.
  - bs=01, ps=0, z=0 -> sequential.
  - bs=10 -> 0x80.
  - bs=11 -> 0x40.
  - Each taken case pulses `flush` once.
- Taken branch to 0x40 while in WAIT for addr 5 -> the response for 5 is dropped (no `inst_valid`); next `inst_pc` = 0x40.
- `stall` high for 4 cycles after a response -> no `imem_req` during stall. Request at the next PC starts the cycle after `stall` falls. A branch to 0x10 during the stall makes that request address 0x10.
- `imem_gnt` held low 3 cycles -> `imem_req` and `imem_addr` are stable throughout, even with `stall`=1. PC increments only on grant.
- PC = 0xFFFFFFFF fetched -> `pc_1` = 0, next fetch at 0. Reset mid-WAIT with `imem_rvalid` arriving next cycle -> no `inst_valid`; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the program counter and issues one-outstanding
// instruction fetches. Taken branches redirect the PC and squash the fetch in flight.

module pc_sequencer_chk #(
    parameter int AW = 32
) (
    input logic          clk,
    input logic          rst_n,
    input logic          taken,
    input logic          imem_req,
    input logic          imem_gnt,
    input logic [AW-1:0] imem_addr,
    input logic          inst_valid,
    input logic          flush
);

    // A pending request may only move when a taken redirect retargets it.
    property p_req_hold;
        @(posedge clk) disable iff (!rst_n)
            (imem_req && !imem_gnt && !taken) |=> (imem_req && $stable(imem_addr));
    endproperty
    a_req_hold: assert property (p_req_hold);

    // A redirect drops the data it races with, so delivery and flush never coincide.
    property p_valid_no_flush;
        @(posedge clk) disable iff (!rst_n)
            inst_valid |-> !flush;
    endproperty
    a_valid_no_flush: assert property (p_valid_no_flush);

endmodule

module pc_sequencer #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          br_valid,
    input  logic [1:0]    bs,
    input  logic          ps,
    input  logic          z,
    input  logic [AW-1:0] bra,
    input  logic [AW-1:0] raa,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic [AW-1:0] pc_1,
    output logic          flush
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HOLD = 2'd1,
        ST_REQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] fetch_pc_r;
    logic          squash_r;
    logic          inst_valid_r;
    logic [31:0]   inst_r;
    logic [AW-1:0] inst_pc_r;
    logic [AW-1:0] pc_1_r;
    logic          flush_r;

    logic [1:0]    sel_s;
    logic [AW-1:0] target_s;
    logic          taken_s;

    // Next-address (MUX C) select and redirect decision; RST ignores branch control.
    always_comb begin
        sel_s    = {bs[1], bs[0] & (bs[1] | (ps ^ z))};
        target_s = bra;
        case (sel_s)
            2'd2:    target_s = raa;
            default: target_s = bra;
        endcase
        if (br_valid && (sel_s != 2'd0) && (state_r != ST_RST)) begin
            taken_s = 1'b1;
        end else begin
            taken_s = 1'b0;
        end
    end

    // Fetch sequencer: state, PC, squash tracking and registered delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RST;
            pc_r         <= RESET_PC;
            fetch_pc_r   <= {AW{1'b0}};
            squash_r     <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= {AW{1'b0}};
            pc_1_r       <= {AW{1'b0}};
            flush_r      <= 1'b0;
        end else begin
            inst_valid_r <= 1'b0;
            flush_r      <= taken_s;
            case (state_r)
                ST_RST: begin
                    state_r <= stall ? ST_HOLD : ST_REQ;
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        state_r    <= ST_WAIT;
                        fetch_pc_r <= pc_r;
                        squash_r   <= taken_s;
                        pc_r       <= pc_r + PC_ONE;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_r  <= stall ? ST_HOLD : ST_REQ;
                        squash_r <= 1'b0;
                        // A redirect in the response cycle kills that response too.
                        if (!squash_r && !taken_s) begin
                            inst_valid_r <= 1'b1;
                            inst_r       <= imem_rdata;
                            inst_pc_r    <= fetch_pc_r;
                            pc_1_r       <= fetch_pc_r + PC_ONE;
                        end
                    end else if (taken_s) begin
                        squash_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_RST;
                end
            endcase
            // Redirect wins over the grant increment.
            if (taken_s) begin
                pc_r <= target_s;
            end
        end
    end

    assign imem_req   = (state_r == ST_REQ);
    assign imem_addr  = pc_r;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign pc_1       = pc_1_r;
    assign flush      = flush_r;

    pc_sequencer_chk #(.AW(AW)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .taken      (taken_s),
        .imem_req   (imem_req),
        .imem_gnt   (imem_gnt),
        .imem_addr  (imem_addr),
        .inst_valid (inst_valid),
        .flush      (flush)
    );

endmodule
